// File: rtl/seq_trigger_pkg.sv
// Shared definitions for the seq_trigger sequence detector: state encoding
// and the progress-counter width derivation.
package seq_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

  // Progress counts 0..DEPTH-1, so it needs ceil(log2(DEPTH)) bits, minimum 1.
  function automatic int calc_pw(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < depth) begin
        w = w + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_trigger_match.sv
// Combinational pattern comparator: selects the pattern word indexed by the
// current progress and flags a match against it and against word 0.
module seq_trigger_match
  import seq_trigger_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic [DEPTH*DW-1:0] i_pattern,
  input  logic [DW-1:0]       i_data,
  input  logic [PW-1:0]       i_progress,
  output logic                o_match_cur,
  output logic                o_match_first
);

  logic [DW-1:0] word_sel;

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_progress == PW'(k)) begin
        word_sel = i_pattern[k*DW +: DW];
      end
    end
  end

  assign o_match_cur   = (i_data == word_sel);
  assign o_match_first = (i_data == i_pattern[DW-1:0]);

endmodule

// File: rtl/seq_trigger.sv
// Sequence detector: fires when DEPTH consecutive strobed words match the
// programmed pattern in order. Arm/clear control, sticky or pulse firing.
module seq_trigger
  import seq_trigger_pkg::*;
#(
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int CW     = 8,
  parameter int STICKY = 1,
  localparam int PW    = calc_pw(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_arm,
  input  logic                i_clear,
  input  logic                i_stb,
  input  logic [DW-1:0]       i_data,
  input  logic [DEPTH*DW-1:0] i_pattern,
  output logic                o_armed,
  output logic                o_triggered,
  output logic [PW-1:0]       o_progress,
  output logic [CW-1:0]       o_fire_count
);

  state_e        state_q, state_d;
  logic [PW-1:0] progress_q, progress_d;
  logic [CW-1:0] count_q, count_d;
  logic          triggered_q, triggered_d;
  logic          match_cur, match_first;

  seq_trigger_match #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .i_pattern     (i_pattern),
    .i_data        (i_data),
    .i_progress    (progress_q),
    .o_match_cur   (match_cur),
    .o_match_first (match_first)
  );

  // Priority: clear, then arm, then strobe.
  always_comb begin
    state_d     = state_q;
    progress_d  = progress_q;
    count_d     = count_q;
    triggered_d = 1'b0;

    if (i_clear) begin
      state_d    = IDLE;
      progress_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_arm) begin
            state_d    = ARMED;
            progress_d = '0;
          end
        end

        ARMED: begin
          if (!i_arm && i_stb) begin
            if (match_cur) begin
              if (progress_q == PW'(DEPTH - 1)) begin
                progress_d  = '0;
                triggered_d = 1'b1;
                if (count_q != {CW{1'b1}}) begin
                  count_d = count_q + CW'(1);
                end
                if (STICKY != 0) begin
                  state_d = FIRED;
                end
              end else begin
                progress_d = progress_q + PW'(1);
              end
            end else if ((DEPTH > 1) && match_first) begin
              // Single-step restart only: a mismatching word that equals
              // word 0 begins a new attempt.
              progress_d = PW'(1);
            end else begin
              progress_d = '0;
            end
          end
        end

        FIRED: begin
          triggered_d = 1'b1;
          progress_d  = '0;
        end

        default: begin
          state_d    = IDLE;
          progress_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      progress_q  <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      progress_q  <= progress_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
    end
  end

  assign o_armed      = (state_q != IDLE);
  assign o_triggered  = triggered_q;
  assign o_progress   = progress_q;
  assign o_fire_count = count_q;

endmodule

// File: tb/tb_seq_trigger.sv
// Directed bench for seq_trigger: a sticky instance driven from a vector
// table, plus pulse-mode and saturating-counter instances on shared inputs.
module tb_seq_trigger;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int PW    = 1;
  localparam logic [31:0] W0 = 32'hdeadbeef;
  localparam logic [31:0] W1 = 32'hcafef00d;

  logic clk = 1'b0;
  logic rst_n;
  logic arm, clear, stb;
  logic [DW-1:0]       data;
  logic [DEPTH*DW-1:0] pattern;

  logic          s_armed, s_trig;
  logic [PW-1:0] s_prog;
  logic [7:0]    s_cnt;
  logic          p_armed, p_trig;
  logic [PW-1:0] p_prog;
  logic [7:0]    p_cnt;
  logic          t_armed, t_trig;
  logic [PW-1:0] t_prog;
  logic [1:0]    t_cnt;

  int vec_count  = 0;
  int miscompare = 0;

  always #5 clk = ~clk;

  seq_trigger #(.DW(DW), .DEPTH(DEPTH), .CW(8), .STICKY(1)) u_sticky (
    .i_clk(clk), .i_reset_n(rst_n), .i_arm(arm), .i_clear(clear), .i_stb(stb),
    .i_data(data), .i_pattern(pattern), .o_armed(s_armed), .o_triggered(s_trig),
    .o_progress(s_prog), .o_fire_count(s_cnt)
  );

  seq_trigger #(.DW(DW), .DEPTH(DEPTH), .CW(8), .STICKY(0)) u_pulse (
    .i_clk(clk), .i_reset_n(rst_n), .i_arm(arm), .i_clear(clear), .i_stb(stb),
    .i_data(data), .i_pattern(pattern), .o_armed(p_armed), .o_triggered(p_trig),
    .o_progress(p_prog), .o_fire_count(p_cnt)
  );

  seq_trigger #(.DW(DW), .DEPTH(DEPTH), .CW(2), .STICKY(0)) u_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_arm(arm), .i_clear(clear), .i_stb(stb),
    .i_data(data), .i_pattern(pattern), .o_armed(t_armed), .o_triggered(t_trig),
    .o_progress(t_prog), .o_fire_count(t_cnt)
  );

  typedef struct {
    logic        clr;
    logic        arm;
    logic        stb;
    logic [31:0] data;
    logic        armed;
    logic        trig;
    logic [PW-1:0] prog;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic c, input logic a, input logic s,
                              input logic [31:0] d, input logic ea,
                              input logic et, input logic [PW-1:0] ep,
                              input logic [7:0] ec);
    vec_t v;
    v.clr = c; v.arm = a; v.stb = s; v.data = d;
    v.armed = ea; v.trig = et; v.prog = ep; v.cnt = ec;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge; return 1ns after the rising edge.
  task automatic applyStimulus(input logic c, input logic a, input logic s,
                               input logic [31:0] d);
    @(negedge clk);
    clear = c; arm = a; stb = s; data = d;
    @(posedge clk);
    #1;
    vec_count++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    if (act !== exp) begin
      miscompare++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 1, W0,            0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, W1,            0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h0,         1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, W0,            1, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         1, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         1, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,         1, 0, 1, 0);
    vecs[7]  = mk(0, 0, 1, W1,            1, 1, 0, 1);
    vecs[8]  = mk(0, 0, 1, W0,            1, 1, 0, 1);
    vecs[9]  = mk(0, 1, 1, W1,            1, 1, 0, 1);
    vecs[10] = mk(1, 1, 0, 32'h0,         0, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 32'h0,         1, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, W0,            1, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, W0,            1, 0, 1, 0);
    vecs[14] = mk(0, 0, 1, W1,            1, 1, 0, 1);
    vecs[15] = mk(1, 0, 0, 32'h0,         0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 32'h0,         1, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, W0,            1, 0, 1, 0);
    vecs[18] = mk(0, 0, 1, 32'h12345678,  1, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, W1,            1, 0, 0, 0);
    vecs[20] = mk(1, 0, 1, W0,            0, 0, 0, 0);

    rst_n = 1'b0; arm = 1'b0; clear = 1'b0; stb = 1'b0; data = '0;
    pattern = {W1, W0};
    repeat (2) @(negedge clk);
    checkOutput("reset armed", 32'(s_armed), 0);
    checkOutput("reset trig",  32'(s_trig),  0);
    checkOutput("reset prog",  32'(s_prog),  0);
    checkOutput("reset count", 32'(s_cnt),   0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].arm, vecs[i].stb, vecs[i].data);
      checkOutput($sformatf("v%0d armed", i), 32'(s_armed), 32'(vecs[i].armed));
      checkOutput($sformatf("v%0d trig",  i), 32'(s_trig),  32'(vecs[i].trig));
      checkOutput($sformatf("v%0d prog",  i), 32'(s_prog),  32'(vecs[i].prog));
      checkOutput($sformatf("v%0d count", i), 32'(s_cnt),   32'(vecs[i].cnt));
    end

    // Pulse mode and saturation: five back-to-back pattern pairs.
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("pulse armed after arm", 32'(p_armed), 1);
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(0, 0, 1, W0);
      checkOutput($sformatf("pulse%0d trig low", n), 32'(p_trig), 0);
      checkOutput($sformatf("pulse%0d prog", n),     32'(p_prog), 1);
      applyStimulus(0, 0, 1, W1);
      checkOutput($sformatf("pulse%0d trig high", n), 32'(p_trig),  1);
      checkOutput($sformatf("pulse%0d count", n),     32'(p_cnt),   n);
      checkOutput($sformatf("pulse%0d armed", n),     32'(p_armed), 1);
      checkOutput($sformatf("sat%0d count", n),       32'(t_cnt),   (n > 3) ? 3 : n);
      checkOutput($sformatf("sat%0d trig", n),        32'(t_trig),  1);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("pulse trig after idle", 32'(p_trig), 0);
    checkOutput("sat count held",        32'(t_cnt),  3);
    checkOutput("sticky fired count",    32'(s_cnt),  1);

    // Asynchronous reset mid-sequence, between clock edges.
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 0, 1, W0);
    checkOutput("pre-reset prog", 32'(s_prog), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async armed", 32'(s_armed), 0);
    checkOutput("async prog",  32'(s_prog),  0);
    checkOutput("async pulse armed", 32'(p_armed), 0);
    checkOutput("async sat count",   32'(t_cnt),   0);
    @(negedge clk);
    stb = 1'b0;
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, W1);
    checkOutput("post-reset trig", 32'(s_trig), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
